pattern_detector_prog: RTL and testbench

PATTERN_DETECTOR_PROG -- requirements
Module: pattern_detector_prog

---
 rtl/pattern_detector_prog.sv | 135 +++++++++++++
 tb/tb_pattern_detector_prog.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_detector_prog.sv
// Programmable serial pattern detector with a runtime-loaded pattern/length,
// overlap or non-overlap matching, and a saturating match counter.
module pattern_detector_prog #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  input  logic             v_i,
  input  logic             d_i,
  output logic             pattern_detect,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err,
  output logic             armed
);

  typedef enum logic [1:0] {UNCFG, FILL, ARMED} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  state_t           state_reg, state_next;
  logic [PAT_W-1:0] shift_reg, shift_next;
  logic [LEN_W-1:0] fill_reg, fill_next;
  logic [PAT_W-1:0] pat_reg, pat_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic             ovl_reg, ovl_next;
  logic             detect_reg, detect_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] shifted;
  logic             len_ok;
  logic             reach;
  logic             match;

  // Compare mask: only the low len_reg bits of the window take part.
  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign mask[gi] = (LEN_W'(gi) < len_reg);
    end
  endgenerate

  assign shifted = {shift_reg[PAT_W-2:0], d_i};
  assign len_ok  = (cfg_len != '0) && (cfg_len <= MAX_LEN);
  // Fill saturates at len, so the window is full once fill+1 hits len or is already there.
  assign reach   = (fill_reg == len_reg) || ((fill_reg + LEN_W'(1)) == len_reg);

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    fill_next  = fill_reg;
    pat_next   = pat_reg;
    len_next   = len_reg;
    ovl_next   = ovl_reg;
    err_next   = 1'b0;
    match      = 1'b0;

    if (cfg_we && len_ok) begin
      pat_next   = cfg_pattern;
      len_next   = cfg_len;
      ovl_next   = cfg_overlap;
      shift_next = '0;
      fill_next  = '0;
      state_next = FILL;
    end else begin
      if (cfg_we) begin
        err_next = 1'b1;
      end
      if (v_i && (state_reg != UNCFG)) begin
        shift_next = shifted;
        if (reach && ((shifted & mask) == (pat_reg & mask))) begin
          match = 1'b1;
          if (ovl_reg) begin
            fill_next  = len_reg;
            state_next = ARMED;
          end else begin
            fill_next  = '0;
            state_next = FILL;
          end
        end else if (reach) begin
          fill_next  = len_reg;
          state_next = ARMED;
        end else begin
          fill_next = fill_reg + LEN_W'(1);
        end
      end
    end

    detect_next = match;

    count_next = count_reg;
    if (cnt_clr) begin
      count_next = '0;
    end else if (match && (count_reg != {CNT_W{1'b1}})) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= UNCFG;
      shift_reg  <= '0;
      fill_reg   <= '0;
      pat_reg    <= '0;
      len_reg    <= '0;
      ovl_reg    <= 1'b0;
      detect_reg <= 1'b0;
      err_reg    <= 1'b0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      fill_reg   <= fill_next;
      pat_reg    <= pat_next;
      len_reg    <= len_next;
      ovl_reg    <= ovl_next;
      detect_reg <= detect_next;
      err_reg    <= err_next;
      count_reg  <= count_next;
    end
  end

  assign pattern_detect = detect_reg;
  assign match_count    = count_reg;
  assign cfg_err        = err_reg;
  assign armed          = (state_reg == ARMED);

endmodule

// File: tb/tb_pattern_detector_prog.sv
// Directed bench for pattern_detector_prog; a second instance with a 2-bit
// counter shares the stimulus to exercise counter saturation.
module tb_pattern_detector_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       v_i = 1'b0;
  logic       d_i = 1'b0;

  logic        det, err, arm;
  logic [15:0] cnt;
  logic        det2, err2, arm2;
  logic [1:0]  cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pattern_detector_prog #(.PAT_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .v_i(v_i), .d_i(d_i), .pattern_detect(det), .match_count(cnt),
    .cfg_err(err), .armed(arm)
  );

  pattern_detector_prog #(.PAT_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .v_i(v_i), .d_i(d_i), .pattern_detect(det2), .match_count(cnt2),
    .cfg_err(err2), .armed(arm2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends n bits MSB-first; exp[i] is the pulse expected right after bits[i].
  task automatic feed(input logic [15:0] bits, input int n, input logic [15:0] exp, input string name);
    for (int i = n - 1; i >= 0; i--) begin
      v_i = 1'b1;
      d_i = bits[i];
      step();
      $display("%s beat %0d d=%b detect=%b count=%0d", name, n - i, d_i, det, cnt);
      checks++;
      if (det !== exp[i]) begin
        errors++;
        $display("FAIL %s bit%0d pattern_detect=%b expected %b", name, n - i, det, exp[i]);
      end
    end
    v_i = 1'b0;
    d_i = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    step();
    cfg_we = 1'b0;
    $display("cfg pat=%b len=%0d ovl=%b err=%b", pat, len, ovl, err);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_legal cfg_err=%b expected 0", err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    $display("reset det=%b cnt=%0d err=%b armed=%b", det, cnt, err, arm);
    checks++;
    if ({det, err, arm, cnt} !== 19'd0) begin
      errors++;
      $display("FAIL reset det/err/armed/cnt=%b/%b/%b/%0d expected all 0", det, err, arm, cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_unconfigured();
    feed(16'b01101, 5, 16'b00000, "uncfg");
    checks++;
    if (arm !== 1'b0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL uncfg armed=%b cnt=%0d expected 0 0", arm, cnt);
    end
  endtask

  task automatic test_nonoverlap();
    cfg(8'b01101, 4'd5, 1'b0);
    feed(16'b0110101101, 10, 16'b0000100001, "nonovl5");
    checks++;
    if (cnt !== 16'd2 || cnt2 !== 2'd2) begin
      errors++;
      $display("FAIL nonovl5_count cnt=%0d cnt2=%0d expected 2 2", cnt, cnt2);
    end
    checks++;
    if (arm !== 1'b0) begin
      errors++;
      $display("FAIL nonovl5_armed armed=%b expected 0", arm);
    end
  endtask

  task automatic test_overlap();
    cfg(8'b1010, 4'd4, 1'b1);
    feed(16'b101010, 6, 16'b000101, "ovl4");
    checks++;
    if (arm !== 1'b1 || cnt !== 16'd4 || cnt2 !== 2'd3) begin
      errors++;
      $display("FAIL ovl4_state armed=%b cnt=%0d cnt2=%0d expected 1 4 3", arm, cnt, cnt2);
    end
    cfg(8'b1010, 4'd4, 1'b0);
    feed(16'b101010, 6, 16'b000100, "nonovl4");
    checks++;
    if (cnt !== 16'd5 || cnt2 !== 2'd3) begin
      errors++;
      $display("FAIL nonovl4_count cnt=%0d cnt2=%0d expected 5 3", cnt, cnt2);
    end
  endtask

  task automatic test_idle_and_cfg_priority();
    cfg(8'b01101, 4'd5, 1'b0);
    feed(16'b0110, 4, 16'b0000, "idle_pre");
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (det !== 1'b0) begin
        errors++;
        $display("FAIL idle_gap cycle%0d pattern_detect=%b expected 0", k, det);
      end
    end
    feed(16'b1, 1, 16'b1, "idle_last");
    step();
    checks++;
    if (det !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width pattern_detect=%b expected 0", det);
    end
    cfg(8'b01101, 4'd5, 1'b0);
    feed(16'b0110, 4, 16'b0000, "cfgpri_pre");
    cfg_we = 1'b1; v_i = 1'b1; d_i = 1'b1;
    step();
    cfg_we = 1'b0; v_i = 1'b0; d_i = 1'b0;
    $display("cfgpri final beat detect=%b armed=%b", det, arm);
    checks++;
    if (det !== 1'b0 || arm !== 1'b0) begin
      errors++;
      $display("FAIL cfg_priority detect=%b armed=%b expected 0 0", det, arm);
    end
    feed(16'b1101, 4, 16'b0000, "cfgpri_cleared");
  endtask

  task automatic test_cfg_err();
    cfg(8'b01101, 4'd5, 1'b0);
    cfg_we = 1'b1; cfg_len = 4'd0; cfg_pattern = 8'hFF; v_i = 1'b1; d_i = 1'b0;
    step();
    cfg_we = 1'b0; v_i = 1'b0;
    $display("cfg_err len=0 err=%b", err);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_len0 cfg_err=%b expected 1", err);
    end
    step();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_pulse cfg_err=%b expected 0", err);
    end
    feed(16'b1101, 4, 16'b0001, "after_len0");
    cfg_we = 1'b1; cfg_len = 4'd9; cfg_pattern = 8'h00;
    step();
    cfg_we = 1'b0;
    $display("cfg_err len=9 err=%b", err);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_len9 cfg_err=%b expected 1", err);
    end
    feed(16'b01101, 5, 16'b00001, "after_len9");
    checks++;
    if (cnt !== 16'd8) begin
      errors++;
      $display("FAIL cfg_err_count cnt=%0d expected 8", cnt);
    end
  endtask

  task automatic test_cnt_clr();
    cfg(8'b01101, 4'd5, 1'b0);
    feed(16'b0110, 4, 16'b0000, "clr_pre");
    cnt_clr = 1'b1; v_i = 1'b1; d_i = 1'b1;
    step();
    cnt_clr = 1'b0; v_i = 1'b0; d_i = 1'b0;
    $display("cnt_clr with match detect=%b cnt=%0d cnt2=%0d", det, cnt, cnt2);
    checks++;
    if (det !== 1'b1 || cnt !== 16'd0 || cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL cnt_clr detect=%b cnt=%0d cnt2=%0d expected 1 0 0", det, cnt, cnt2);
    end
  endtask

  task automatic test_len1();
    cfg(8'b00000001, 4'd1, 1'b0);
    feed(16'b1011, 4, 16'b1011, "len1_nonovl");
    cfg(8'b11111110, 4'd1, 1'b1);
    feed(16'b1001, 4, 16'b0110, "len1_ovl");
    checks++;
    if (cnt !== 16'd5 || cnt2 !== 2'd3) begin
      errors++;
      $display("FAIL len1_count cnt=%0d cnt2=%0d expected 5 3", cnt, cnt2);
    end
  endtask

  task automatic test_reset_mid();
    cfg(8'b01101, 4'd5, 1'b0);
    feed(16'b011, 3, 16'b000, "rstmid_pre");
    rst = 1'b1; cfg_we = 1'b1; v_i = 1'b1; d_i = 1'b0; cnt_clr = 1'b0;
    step();
    rst = 1'b0; cfg_we = 1'b0; v_i = 1'b0;
    $display("rstmid det=%b cnt=%0d err=%b armed=%b", det, cnt, err, arm);
    checks++;
    if ({det, err, arm, cnt} !== 19'd0) begin
      errors++;
      $display("FAIL rstmid det/err/armed/cnt=%b/%b/%b/%0d expected all 0", det, err, arm, cnt);
    end
    feed(16'b01, 2, 16'b00, "rstmid_rest");
    feed(16'b01101, 5, 16'b00000, "rstmid_uncfg");
    checks++;
    if (arm !== 1'b0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_uncfg armed=%b cnt=%0d expected 0 0", arm, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_unconfigured();
    test_nonoverlap();
    test_overlap();
    test_idle_and_cfg_priority();
    test_cfg_err();
    test_cnt_clr();
    test_len1();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
